// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers.
// Holds the field widths of the EX/MEM payload, the packed payload struct,
// the bubble control values and the occupancy encoding of the skid register.
// No ports: this file is a package imported by the EX/MEM stage files.
package mips_pipe_pkg;

    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] pc;
        logic              zero;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  wreg;
    } ex_mem_t;

    // A bubble is any payload whose control fields are zero: it can neither
    // write the register file nor touch memory.
    localparam logic [WB_W-1:0] BUBBLE_WB = '0;
    localparam logic [M_W-1:0]  BUBBLE_M  = '0;

    // How many instructions the stage currently holds.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Turn a payload into a bubble while keeping its data fields.
    function automatic ex_mem_t make_bubble(input ex_mem_t p);
        ex_mem_t r;
        r    = p;
        r.wb = BUBBLE_WB;
        r.m  = BUBBLE_M;
        return r;
    endfunction

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// Handshake and payload bundle between EX, the EX/MEM skid register and MEM.
// Upstream side : in_valid, in_ready, flush, WB, M, PC, zero, ALUresult,
//                 writeData, writeRegister.
// Downstream side: out_ready, valid_output and the *_output payload fields.
// modport slave  : the pipeline register itself.
// modport master : the environment driving it (EX + MEM).
interface ex_mem_skid_reg_if;
    import mips_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [WB_W-1:0]   WB;
    logic [M_W-1:0]    M;
    logic [DATA_W-1:0] PC;
    logic              zero;
    logic [DATA_W-1:0] ALUresult;
    logic [DATA_W-1:0] writeData;
    logic [REG_W-1:0]  writeRegister;

    logic              out_ready;
    logic              valid_output;
    logic [WB_W-1:0]   WB_output;
    logic [M_W-1:0]    M_output;
    logic [DATA_W-1:0] PC_output;
    logic              zero_output;
    logic [DATA_W-1:0] ALUresult_output;
    logic [DATA_W-1:0] writeData_output;
    logic [REG_W-1:0]  writeRegister_output;

    modport slave (
        input  in_valid, flush, WB, M, PC, zero, ALUresult, writeData,
               writeRegister, out_ready,
        output in_ready, valid_output, WB_output, M_output, PC_output,
               zero_output, ALUresult_output, writeData_output,
               writeRegister_output
    );

    modport master (
        output in_valid, flush, WB, M, PC, zero, ALUresult, writeData,
               writeRegister, out_ready,
        input  in_ready, valid_output, WB_output, M_output, PC_output,
               zero_output, ALUresult_output, writeData_output,
               writeRegister_output
    );

endinterface

// File: rtl/ex_mem_slot.sv
// One EX/MEM payload register, used for both the main and the skid entry.
// Ports:
//   clk, rst     clock and asynchronous active-high reset (clears to zero)
//   load         capture d on the next rising edge
//   clear_ctrl   zero the WB/M control fields, keep the data fields;
//                wins over load so a killed instruction never lands
//   d, q         payload in / registered payload out
module ex_mem_slot
    import mips_pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    clear_ctrl,
    input  ex_mem_t d,
    output ex_mem_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear_ctrl) begin
            q <= make_bubble(q);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with valid bit, flush-to-bubble and a two-entry
// skid buffer. The main slot drives MEM; the skid slot catches the one
// instruction EX may send in the cycle MEM first stalls, which lets in_ready
// be a plain flop instead of a combinational function of out_ready.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, empties both slots
//   bus  ex_mem_skid_reg_if.slave: upstream valid/ready/flush + payload,
//        downstream out_ready/valid_output + registered payload
module ex_mem_skid_reg
    import mips_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ex_mem_skid_reg_if.slave      bus
);

    occ_e    occ;
    occ_e    occ_next;
    logic    valid_q;
    logic    in_ready_q;

    logic    accept;
    logic    emit;

    logic    main_load;
    logic    main_clr;
    ex_mem_t main_d;
    ex_mem_t main_q;

    logic    skid_load;
    logic    skid_clr;
    ex_mem_t skid_q;

    ex_mem_t in_payload;

    assign in_payload = '{
        wb:    bus.WB,
        m:     bus.M,
        pc:    bus.PC,
        zero:  bus.zero,
        alu:   bus.ALUresult,
        wdata: bus.writeData,
        wreg:  bus.writeRegister
    };

    assign accept = bus.in_valid & in_ready_q;
    assign emit   = valid_q & bus.out_ready;

    // Decide what each slot does this cycle and where occupancy goes.
    // Flush overrides everything: both slots become bubbles and any offered
    // instruction is dropped. An emit that coincides with flush still counts
    // for MEM because MEM samples the current outputs before the edge.
    always_comb begin
        occ_next  = occ;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_d    = in_payload;
        skid_load = 1'b0;
        skid_clr  = 1'b0;

        if (bus.flush) begin
            occ_next = OCC_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        occ_next  = OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        occ_next  = OCC_FULL;
                    end else if (emit) begin
                        // Leaving empty: scrub control so the idle output is a bubble.
                        main_clr = 1'b1;
                        occ_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (emit) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_clr  = 1'b1;
                        occ_next  = OCC_MAIN;
                    end
                end
                default: begin
                    occ_next = OCC_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state plus its registered decodes. valid and ready are
    // computed from the next state so both are clean flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= OCC_EMPTY;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            occ        <= occ_next;
            valid_q    <= (occ_next != OCC_EMPTY);
            in_ready_q <= (occ_next != OCC_FULL);
        end
    end

    ex_mem_slot u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .clear_ctrl (main_clr),
        .d          (main_d),
        .q          (main_q)
    );

    ex_mem_slot u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear_ctrl (skid_clr),
        .d          (in_payload),
        .q          (skid_q)
    );

    assign bus.in_ready             = in_ready_q;
    assign bus.valid_output         = valid_q;
    assign bus.WB_output            = main_q.wb;
    assign bus.M_output             = main_q.m;
    assign bus.PC_output            = main_q.pc;
    assign bus.zero_output          = main_q.zero;
    assign bus.ALUresult_output     = main_q.alu;
    assign bus.writeData_output     = main_q.wdata;
    assign bus.writeRegister_output = main_q.wreg;

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
Parametrised successor of the EX/MEM pipeline register for the MIPS pipeline. Carries the WB/M control fields, PC, zero flag, ALU result, store data and destination register from EX to MEM. Adds reset, a valid bit, a flush that inserts a bubble, and a two-entry skid buffer with valid/ready handshake, so MEM can stall without a combinational ready path back into EX.

Parameters:
WB_W, 2, width of write-back control field
M_W, 3, width of memory control field
DATA_W, 32, width of PC, ALU result and store data
REG_W, 5, width of destination register index

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  EX presents a valid instruction
in_ready  output  1  stage can accept; registered, equals NOT skid_full
flush  input  1  kill all held and incoming instructions (branch taken or exception)
WB  input  WB_W  write-back control
M  input  M_W  memory control
PC  input  DATA_W  branch target / PC
zero  input  1  ALU zero flag
ALUresult  input  DATA_W  ALU result
writeData  input  DATA_W  store data
writeRegister  input  REG_W  destination register
out_ready  input  1  MEM accepts this cycle
valid_output  output  1  output slot holds a live instruction
WB_output, M_output, PC_output, zero_output, ALUresult_output, writeData_output, writeRegister_output  output  same widths as inputs  registered payload

Behaviour:
- Reset (async, rst=1): valid_output=0, skid_full=0, in_ready=1. All payload outputs 0. Skid payload 0.
- Storage: main slot drives the outputs; skid slot holds one extra entry. Occupancy is 0, 1 (main only) or 2 (main+skid). Skid is never valid while main is empty.
- accept = in_valid & in_ready; emit = valid_output & out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when main is empty or being emitted.
- Per rising edge, with flush=0:
  - occ 0: accept -> main<=input, occ 1.
  - occ 1: accept & emit -> main<=input, occ 1. Accept & no emit -> skid<=input, occ 2. Emit only -> occ 0. Neither -> hold.
  - occ 2: in_ready=0, so no accept. Emit -> main<=skid, occ 1. No emit -> hold.
- Order: the outputs follow accept order. No instruction is lost or duplicated while flush=0.
- Flush (sync, priority over everything): next edge valid_output=0, skid_full=0, in_ready=1. WB_output and M_output are cleared to 0, so the bubble cannot write or access memory. The other payload fields hold. An instruction offered in the same cycle is dropped even if in_valid=1.
- Simultaneous flush & emit: the emit still happens in that cycle (MEM samples the current outputs), and the stage is empty after the edge.
- While valid_output=0, WB_output and M_output are always 0, including after emit-to-empty. Data fields are don't-care.
- in_ready is a flop; it never depends combinationally on out_ready.
- rst asserted mid-operation clears both slots immediately, regardless of the clock.

Decomposition:
- Shared package (mips_pipe_pkg) holds:
  - constants WB_W, M_W, DATA_W, REG_W
  - packed struct ex_mem_t {wb, m, pc, zero, alu, wdata, wreg}
  - localparam for the bubble value (ctrl zero)
- One natural sub-module: ex_mem_slot. It is a single payload register with load enable and control-clear, and is instantiated for main and skid. The handshake/occupancy logic lives in the top.

Test Plan:
- Reset: assert rst mid-clock with occ 2 -> immediately valid_output=0, in_ready=1, WB_output=0, M_output=0.
- Streaming: out_ready=1, send ALUresult 3, 4, 5 with in_valid=1 on consecutive cycles -> valid_output=1 and ALUresult_output 3, 4, 5 on the following consecutive cycles, in_ready stays 1.
- Stall: out_ready=0, send WB=2'b01, ALUresult=0x11, then ALUresult=0x22 -> in_ready=0 after the second; outputs hold 0x11. Release out_ready -> 0x11 then 0x22, then in_ready=1.
- Flush at occ 2 with in_valid=1, ALUresult=0x33 -> next cycle valid_output=0, WB_output=0, M_output=0, in_ready=1; 0x33 is never emitted.
- Flush & emit together: occ 1 holding writeRegister=5'b11111, out_ready=1, flush=1 -> MEM sees 5'b11111 that cycle; the next cycle is empty.
- Back-to-back random in_valid/out_ready for 1000 cycles with a scoreboard -> in-order, no loss or duplication, occupancy never exceeds 2.
